// File: rtl/result_packetizer.sv
// Result packetizer: turns one distance-processor result (lowest, highest,
// hitvector) into an 8-byte response frame for the UART transmitter.
// Frame: HEADER, lowest lo/hi, highest lo/hi, hitvector lo/hi, CHK, where
// CHK makes the mod-256 sum of bytes 1..7 equal zero. A configurable idle gap
// follows every frame before another result is accepted.
module result_packetizer #(
  parameter logic [7:0]  HEADER     = 8'hA5,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flashin,
  input  logic [15:0] lowest,
  input  logic [15:0] highest,
  input  logic [15:0] hitvector,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Terminal value of the gap counter; unused when the gap is disabled.
  localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t      state;
  logic [2:0]  idx;
  logic [15:0] cap_low;
  logic [15:0] cap_high;
  logic [15:0] cap_hit;
  logic [15:0] gap_cnt;

  logic [2:0]  next_idx;
  logic [7:0]  payload_sum;
  logic [7:0]  chk;
  logic [7:0]  next_byte;

  // Select the byte that follows the current one, checksum taken from the captured result.
  always_comb begin
    next_idx    = idx + 3'd1;
    payload_sum = cap_low[7:0] + cap_low[15:8] + cap_high[7:0] + cap_high[15:8]
                + cap_hit[7:0] + cap_hit[15:8];
    chk         = ~payload_sum + 8'd1;
    next_byte   = 8'h00;
    case (next_idx)
      3'd0:    next_byte = HEADER;
      3'd1:    next_byte = cap_low[7:0];
      3'd2:    next_byte = cap_low[15:8];
      3'd3:    next_byte = cap_high[7:0];
      3'd4:    next_byte = cap_high[15:8];
      3'd5:    next_byte = cap_hit[7:0];
      3'd6:    next_byte = cap_hit[15:8];
      default: next_byte = chk;
    endcase
  end

  // Frame sequencer: capture in IDLE, hand bytes out under valid/ready, then hold off for the gap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cap_low    <= 16'd0;
      cap_high   <= 16'd0;
      cap_hit    <= 16'd0;
      gap_cnt    <= 16'd0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (flashin) begin
            cap_low    <= lowest;
            cap_high   <= highest;
            cap_hit    <= hitvector;
            idx        <= 3'd0;
            byte_out   <= HEADER;
            byte_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (flashin) begin
            overrun <= 1'b1;
          end
          if (byte_valid && byte_ready) begin
            if (idx != 3'd7) begin
              idx      <= next_idx;
              byte_out <= next_byte;
            end else begin
              idx        <= 3'd0;
              byte_valid <= 1'b0;
              frame_done <= 1'b1;
              gap_cnt    <= 16'd0;
              if (GAP_CYCLES > 0) begin
                state <= GAP;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          if (flashin) begin
            overrun <= 1'b1;
          end
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          byte_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_packetizer.sv
// Directed bench for result_packetizer: frame contents, checksum corners,
// backpressure, overrun, mid-frame reset, and a zero-gap build.
module tb_result_packetizer;

  logic        clock = 1'b0;
  logic        reset;
  logic        flashin;
  logic [15:0] lowest;
  logic [15:0] highest;
  logic [15:0] hitvector;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  logic        flashin0;
  logic        byte_ready0;
  logic [7:0]  byte_out0;
  logic        byte_valid0;
  logic        busy0;
  logic        frame_done0;
  logic        overrun0;

  int checks = 0;
  int errors = 0;

  // Hand-computed frames.
  logic [7:0] f1 [8] = '{8'hA5, 8'h34, 8'h12, 8'h78, 8'h56, 8'hF0, 8'h00, 8'hFC};
  logic [7:0] ff [8] = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h06};
  logic [7:0] fz [8] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] fc [8] = '{8'hA5, 8'h02, 8'h01, 8'h04, 8'h03, 8'h01, 8'h80, 8'h75};

  result_packetizer #(.HEADER(8'hA5), .GAP_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .flashin(flashin),
    .lowest(lowest), .highest(highest), .hitvector(hitvector),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  result_packetizer #(.HEADER(8'hA5), .GAP_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .flashin(flashin0),
    .lowest(lowest), .highest(highest), .hitvector(hitvector),
    .byte_out(byte_out0), .byte_valid(byte_valid0), .byte_ready(byte_ready0),
    .busy(busy0), .frame_done(frame_done0), .overrun(overrun0)
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
      $error("[TB] %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      $error("[TB] %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Present a result for one cycle; afterwards the first byte should be showing.
  task automatic apply_stimulus(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] hv);
    lowest    = lo;
    highest   = hi;
    hitvector = hv;
    flashin   = 1'b1;
    tick();
    flashin   = 1'b0;
  endtask

  // Drain a frame at one byte per clock; optionally fire a stray flashin at byte inject_at.
  task automatic check_output(input logic [7:0] frm [8], input int inject_at, input string tag);
    byte_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_bit({tag, " valid"}, byte_valid, 1'b1);
      chk_byte($sformatf("%s byte%0d", tag, i), byte_out, frm[i]);
      if (i == inject_at) begin
        flashin   = 1'b1;
        lowest    = 16'hDEAD;
        highest   = 16'hBEEF;
        hitvector = 16'h5A5A;
      end
      tick();
      flashin = 1'b0;
      chk_bit($sformatf("%s overrun%0d", tag, i), overrun, (i == inject_at));
    end
    chk_bit({tag, " done"}, frame_done, 1'b1);
    chk_bit({tag, " valid after"}, byte_valid, 1'b0);
    chk_bit({tag, " busy after"}, busy, 1'b1);
  endtask

  // Walk through the idle gap, optionally firing a stray flashin at gap cycle inject.
  task automatic wait_gap(input int inject, input string tag);
    for (int k = 0; k < 16; k++) begin
      if (k == inject) begin
        flashin = 1'b1;
        lowest  = 16'h7777;
      end
      tick();
      flashin = 1'b0;
      chk_bit($sformatf("%s gap overrun%0d", tag, k), overrun, (k == inject));
      chk_bit($sformatf("%s gap busy%0d", tag, k), busy, (k < 15));
      chk_bit($sformatf("%s gap valid%0d", tag, k), byte_valid, 1'b0);
      chk_bit($sformatf("%s gap done%0d", tag, k), frame_done, 1'b0);
    end
  endtask

  // Drain a frame under random backpressure with two forced 20-cycle stalls.
  task automatic collect_random(input logic [7:0] frm [8], input string tag);
    int         n;
    int         cycles;
    int         stall;
    bit         held;
    bit         r;
    bit         did2;
    bit         did5;
    logic [7:0] held_byte;
    n = 0; cycles = 0; stall = 0; held = 0; did2 = 0; did5 = 0; held_byte = 8'h00;
    while (n < 8 && cycles < 600) begin
      if (held) begin
        chk_bit({tag, " stall valid"}, byte_valid, 1'b1);
        chk_byte({tag, " stall byte"}, byte_out, held_byte);
      end
      if (stall == 0 && n == 2 && !did2) begin stall = 20; did2 = 1; end
      if (stall == 0 && n == 5 && !did5) begin stall = 20; did5 = 1; end
      if (stall > 0) begin
        r = 1'b0;
        stall--;
      end else begin
        r = ($urandom_range(0, 9) < 3);
      end
      if (byte_valid && r) begin
        chk_byte($sformatf("%s byte%0d", tag, n), byte_out, frm[n]);
        n++;
      end
      held      = byte_valid && !r;
      held_byte = byte_out;
      byte_ready = r;
      tick();
      cycles++;
    end
    byte_ready = 1'b0;
    chk_bit({tag, " completed in budget"}, (n == 8), 1'b1);
    chk_bit({tag, " done"}, frame_done, 1'b1);
    chk_bit({tag, " valid after"}, byte_valid, 1'b0);
  endtask

  initial begin
    reset       = 1'b0;
    flashin     = 1'b0;
    flashin0    = 1'b0;
    byte_ready  = 1'b0;
    byte_ready0 = 1'b1;
    lowest      = 16'h0;
    highest     = 16'h0;
    hitvector   = 16'h0;

    // Reset state.
    tick();
    tick();
    chk_bit("reset valid", byte_valid, 1'b0);
    chk_byte("reset byte", byte_out, 8'h00);
    chk_bit("reset busy", busy, 1'b0);
    chk_bit("reset done", frame_done, 1'b0);
    chk_bit("reset overrun", overrun, 1'b0);
    chk_bit("reset0 valid", byte_valid0, 1'b0);
    chk_bit("reset0 busy", busy0, 1'b0);
    reset = 1'b1;
    tick();

    $display("[TB] normal frame");
    byte_ready = 1'b1;
    apply_stimulus(16'h1234, 16'h5678, 16'h00F0);
    check_output(f1, -1, "s1");
    wait_gap(-1, "s1");

    $display("[TB] checksum corners");
    apply_stimulus(16'hFFFF, 16'hFFFF, 16'hFFFF);
    check_output(ff, -1, "ones");
    wait_gap(-1, "ones");
    apply_stimulus(16'h0000, 16'h0000, 16'h0000);
    check_output(fz, 7, "zeros");
    wait_gap(-1, "zeros");
    tick();
    chk_bit("no frame after final-byte flash", byte_valid, 1'b0);

    $display("[TB] backpressure");
    byte_ready = 1'b0;
    apply_stimulus(16'h1234, 16'h5678, 16'h00F0);
    collect_random(f1, "bp");
    wait_gap(-1, "bp");

    $display("[TB] overrun");
    apply_stimulus(16'h1234, 16'h5678, 16'h00F0);
    check_output(f1, 3, "ovr");
    wait_gap(5, "ovr");
    tick();
    chk_bit("ovr no second frame", byte_valid, 1'b0);
    chk_bit("ovr idle", busy, 1'b0);
    apply_stimulus(16'h0102, 16'h0304, 16'h8001);
    check_output(fc, -1, "after gap");
    wait_gap(-1, "after gap");

    $display("[TB] reset mid-frame");
    apply_stimulus(16'h0102, 16'h0304, 16'h8001);
    for (int i = 0; i < 5; i++) begin
      chk_byte($sformatf("mid byte%0d", i), byte_out, fc[i]);
      tick();
    end
    chk_byte("mid byte5 showing", byte_out, fc[5]);
    reset   = 1'b0;
    flashin = 1'b1;
    tick();
    flashin = 1'b0;
    chk_bit("mid reset valid", byte_valid, 1'b0);
    chk_bit("mid reset busy", busy, 1'b0);
    chk_bit("mid reset done", frame_done, 1'b0);
    chk_byte("mid reset byte", byte_out, 8'h00);
    reset = 1'b1;
    tick();
    chk_bit("mid no resume", byte_valid, 1'b0);
    chk_bit("mid no capture", busy, 1'b0);
    apply_stimulus(16'h0102, 16'h0304, 16'h8001);
    check_output(fc, -1, "fresh");
    wait_gap(-1, "fresh");

    $display("[TB] zero-gap build");
    lowest    = 16'h1234;
    highest   = 16'h5678;
    hitvector = 16'h00F0;
    flashin0  = 1'b1;
    tick();
    flashin0  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_bit("g0 valid", byte_valid0, 1'b1);
      chk_byte($sformatf("g0 byte%0d", i), byte_out0, f1[i]);
      tick();
    end
    chk_bit("g0 done", frame_done0, 1'b1);
    chk_bit("g0 busy", busy0, 1'b0);
    chk_bit("g0 valid after", byte_valid0, 1'b0);
    lowest    = 16'h0102;
    highest   = 16'h0304;
    hitvector = 16'h8001;
    flashin0  = 1'b1;
    tick();
    flashin0  = 1'b0;
    chk_bit("g0 no overrun", overrun0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_bit("g0b valid", byte_valid0, 1'b1);
      chk_byte($sformatf("g0b byte%0d", i), byte_out0, fc[i]);
      tick();
    end
    chk_bit("g0b done", frame_done0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
